// File: rtl/pc_next_unit_if.sv
// pc_next_unit_if: select/operand inputs and PC outputs of the program-counter unit.
// The redirect flag is present only when PC_REDIRECT_FLAG_EN is defined.
interface pc_next_unit_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic             jal;
    logic             branch;
    logic             b_cond;
    logic             pcsrc2;
    logic [WIDTH-1:0] immediate;
    logic [WIDTH-1:0] alu_output;
    logic [WIDTH-1:0] pc_value_output;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] next_pc;
`ifdef PC_REDIRECT_FLAG_EN
    logic             redirect;
`endif

    modport master (
        output stall, jal, branch, b_cond, pcsrc2, immediate, alu_output,
`ifdef PC_REDIRECT_FLAG_EN
        input  redirect,
`endif
        input  pc_value_output, pc_plus1, next_pc
    );

    modport slave (
        input  stall, jal, branch, b_cond, pcsrc2, immediate, alu_output,
`ifdef PC_REDIRECT_FLAG_EN
        output redirect,
`endif
        output pc_value_output, pc_plus1, next_pc
    );
endinterface

// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register plus sequential/branch/JAL/register next-PC selection.
// Optional PC_REDIRECT_FLAG_EN adds redirect = (next_pc != pc_plus1).
module pc_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = a_i + b_i;
endmodule

module pc_mux2 #(
    parameter int WIDTH = 16
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] a1_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = sel_i ? a1_i : a0_i;
endmodule

module pc_next_unit #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] PC_INC   = 1
) (
    input logic         clk,
    input logic         reset_n,
    pc_next_unit_if.slave bus
);
    logic [WIDTH-1:0] pc_q, pc_d, plus1, target, src1, nxt;
    logic             take_rel;

    assign take_rel = bus.jal | (bus.branch & bus.b_cond);

    pc_adder #(.WIDTH(WIDTH)) u_inc (.a_i(pc_q),  .b_i(PC_INC),        .y_o(plus1));
    pc_adder #(.WIDTH(WIDTH)) u_tgt (.a_i(plus1), .b_i(bus.immediate), .y_o(target));
    pc_mux2  #(.WIDTH(WIDTH)) u_rel (.sel_i(take_rel),   .a0_i(plus1), .a1_i(target),         .y_o(src1));
    pc_mux2  #(.WIDTH(WIDTH)) u_reg (.sel_i(bus.pcsrc2), .a0_i(src1),  .a1_i(bus.alu_output), .y_o(nxt));

    assign pc_d = bus.stall ? pc_q : nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc_q <= RESET_PC;
        else          pc_q <= pc_d;
    end

    assign bus.pc_value_output = pc_q;
    assign bus.pc_plus1        = plus1;
    assign bus.next_pc         = nxt;
`ifdef PC_REDIRECT_FLAG_EN
    assign bus.redirect        = (nxt != plus1);
`endif
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed scoreboard bench for pc_next_unit.
module tb_pc_next_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] pc;
        logic [15:0] p1;
        logic [15:0] np;
        logic        rd;
    } exp_t;
    exp_t sb[$];

    pc_next_unit_if #(.WIDTH(16)) bus ();
    pc_next_unit #(.WIDTH(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [15:0] pc, input logic [15:0] p1,
                        input logic [15:0] np, input logic rd);
        exp_t e;
        e.tag = tag; e.pc = pc; e.p1 = p1; e.np = np; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (bus.pc_value_output === e.pc) else begin
            errors++;
            $error("FAIL %s.pc: got %h expected %h", e.tag, bus.pc_value_output, e.pc);
        end
        checks++;
        assert (bus.pc_plus1 === e.p1) else begin
            errors++;
            $error("FAIL %s.pc_plus1: got %h expected %h", e.tag, bus.pc_plus1, e.p1);
        end
        checks++;
        assert (bus.next_pc === e.np) else begin
            errors++;
            $error("FAIL %s.next_pc: got %h expected %h", e.tag, bus.next_pc, e.np);
        end
`ifdef PC_REDIRECT_FLAG_EN
        checks++;
        assert (bus.redirect === e.rd) else begin
            errors++;
            $error("FAIL %s.redirect: got %b expected %b", e.tag, bus.redirect, e.rd);
        end
`endif
    endtask

    task automatic idle();
        bus.stall = 0; bus.jal = 0; bus.branch = 0; bus.b_cond = 0; bus.pcsrc2 = 0;
        bus.immediate = '0; bus.alu_output = '0;
    endtask

    task automatic edge_check(input string tag, input logic [15:0] pc, input logic [15:0] p1,
                              input logic [15:0] np, input logic rd);
        push(tag, pc, p1, np, rd);
        @(posedge clk); #1;
        check();
    endtask

    task automatic comb_check(input string tag, input logic [15:0] pc, input logic [15:0] p1,
                              input logic [15:0] np, input logic rd);
        push(tag, pc, p1, np, rd);
        #1;
        check();
    endtask

    task automatic load_pc(input logic [15:0] v);
        @(negedge clk);
        idle(); bus.pcsrc2 = 1; bus.alu_output = v;
        @(posedge clk); #1;
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        #3 reset_n = 1'b0;
        comb_check("reset_async", 16'h0000, 16'h0001, 16'h0001, 1'b0);
        edge_check("reset_holds", 16'h0000, 16'h0001, 16'h0001, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        edge_check("seq1", 16'h0001, 16'h0002, 16'h0002, 1'b0);
        edge_check("seq2", 16'h0002, 16'h0003, 16'h0003, 1'b0);
        edge_check("seq3", 16'h0003, 16'h0004, 16'h0004, 1'b0);
        @(negedge clk) bus.stall = 1;
        edge_check("stall1", 16'h0003, 16'h0004, 16'h0004, 1'b0);
        edge_check("stall2", 16'h0003, 16'h0004, 16'h0004, 1'b0);
        load_pc(16'h0010);
        bus.branch = 1; bus.b_cond = 1; bus.immediate = 16'hFFFC;
        comb_check("br_taken", 16'h0010, 16'h0011, 16'h000D, 1'b1);
        bus.b_cond = 0;
        comb_check("br_not_taken", 16'h0010, 16'h0011, 16'h0011, 1'b0);
        bus.b_cond = 1;
        edge_check("br_latency", 16'h000D, 16'h000E, 16'h000A, 1'b1);
        load_pc(16'h0005);
        bus.jal = 1; bus.immediate = 16'h0004;
        comb_check("jal", 16'h0005, 16'h0006, 16'h000A, 1'b1);
        bus.pcsrc2 = 1; bus.alu_output = 16'h1234;
        comb_check("priority", 16'h0005, 16'h0006, 16'h1234, 1'b1);
        load_pc(16'hFFFF);
        comb_check("wrap", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
        bus.pcsrc2 = 1; bus.alu_output = 16'h0040;
        comb_check("wrap_redirect", 16'hFFFF, 16'h0000, 16'h0040, 1'b1);
        edge_check("reg_jump", 16'h0040, 16'h0041, 16'h0040, 1'b1);
        @(negedge clk);
        idle();
        #2 reset_n = 1'b0;
        comb_check("reset_midop", 16'h0000, 16'h0001, 16'h0001, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        edge_check("post_reset", 16'h0001, 16'h0002, 16'h0002, 1'b0);
        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
